// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op codes, FSM states and the shift-op classifier.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_XOR  = 4'b0000,
    OP_SLL  = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_AND  = 4'b0011,
    OP_SRA  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_OR   = 4'b1000,
    OP_SLTU = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    SHIFT,
    DONE
  } alu_state_e;

  function automatic logic is_shift_op(input alu_op_e op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single-step shifter: moves data by i_amt positions in the direction
// and fill mode selected by the shift op code; non-shift codes pass data through.
module alu_shift_step #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 6
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [AMT_W-1:0] i_amt,
  input  logic [3:0]       i_op,
  output logic [WIDTH-1:0] o_data
);
  import alu_pkg::*;

  alu_op_e w_op;
  assign w_op = alu_op_e'(i_op);

  always_comb begin
    o_data = i_data;
    case (w_op)
      OP_SLL:  o_data = i_data << i_amt;
      OP_SRL:  o_data = i_data >> i_amt;
      OP_SRA:  o_data = $unsigned($signed(i_data) >>> i_amt);
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked execute unit: logic/arith ops resolve in one cycle, shifts iterate SHIFT_STEP
// bits per cycle. Define ALU_SLT_EN to add the SLT/SLTU compare ops.
module alu_seq_unit #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alucontrol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal_op
);
  import alu_pkg::*;

  localparam int SW = $clog2(WIDTH);
  localparam int AW = SW + 1;
  localparam logic [AW-1:0] STEP_AMT = AW'(SHIFT_STEP);

  alu_state_e       r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_illegal;
  logic [WIDTH-1:0] r_work;
  logic [SW-1:0]    r_remain;
  alu_op_e          r_op;

  alu_op_e          w_op;
  logic [SW-1:0]    w_shamt;
  logic             w_accept;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_illegal;
  logic [AW-1:0]    w_remain_ext;
  logic [AW-1:0]    w_step;
  logic [SW-1:0]    w_remain_next;
  logic [WIDTH-1:0] w_shift_out;

  assign w_op     = alu_op_e'(alucontrol);
  assign w_shamt  = b[SW-1:0];
  assign w_accept = in_valid && r_in_ready;

  // Single-cycle datapath works straight off the inputs in the accepting cycle, so
  // its result lands in DONE without an EXEC stage. Shift codes yield a (shamt = 0).
  always_comb begin
    w_alu_res     = '0;
    w_alu_illegal = 1'b0;
    case (w_op)
      OP_ADD:                 w_alu_res = a + b;
      OP_SUB:                 w_alu_res = a - b;
      OP_XOR:                 w_alu_res = a ^ b;
      OP_AND:                 w_alu_res = a & b;
      OP_OR:                  w_alu_res = a | b;
      OP_SLL, OP_SRL, OP_SRA: w_alu_res = a;
`ifdef ALU_SLT_EN
      OP_SLT:                 w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU:                w_alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
`endif
      default:                w_alu_illegal = 1'b1;
    endcase
  end

  assign w_remain_ext  = {1'b0, r_remain};
  assign w_step        = (w_remain_ext > STEP_AMT) ? STEP_AMT : w_remain_ext;
  assign w_remain_next = r_remain - w_step[SW-1:0];

  alu_shift_step #(
    .WIDTH (WIDTH),
    .AMT_W (AW)
  ) u_shift (
    .i_data (r_work),
    .i_amt  (w_step),
    .i_op   (r_op),
    .o_data (w_shift_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
      r_work      <= '0;
      r_remain    <= '0;
      r_op        <= OP_XOR;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_in_ready <= 1'b0;
            r_op       <= w_op;
            r_work     <= a;
            r_remain   <= w_shamt;
            if (is_shift_op(w_op) && (w_shamt != '0)) begin
              r_state <= SHIFT;
            end else begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_result    <= w_alu_res;
              r_zero      <= (w_alu_res == '0);
              r_illegal   <= w_alu_illegal;
            end
          end
        end
        SHIFT: begin
          r_work   <= w_shift_out;
          r_remain <= w_remain_next;
          // Result is only published once the last step is done.
          if (w_remain_next == '0) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_shift_out;
            r_zero      <= (w_shift_out == '0);
            r_illegal   <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign result     = r_result;
  assign zero       = r_zero;
  assign illegal_op = r_illegal;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed self-checking bench for alu_seq_unit (WIDTH=32, SHIFT_STEP=1).
module tb_alu_seq_unit;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alucontrol;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal_op;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  alu_seq_unit #(
    .WIDTH      (32),
    .SHIFT_STEP (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .alucontrol (alucontrol),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .illegal_op (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait (bounded) for out_valid, check latency/result/flags, then drain.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] er, input logic ez,
                        input logic ei, input int elat);
    int lat;
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid   = 1'b1;
    alucontrol = op;
    a          = va;
    b          = vb;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat = lat + 1;
    end
    check({tag, "_latency"}, 32'(lat), 32'(elat));
    check({tag, "_result"}, result, er);
    check({tag, "_zero"}, 32'(zero), 32'(ez));
    check({tag, "_illegal"}, 32'(illegal_op), 32'(ei));
    $display("op %s code=%b a=%h b=%h -> result=%h zero=%b illegal=%b latency=%0d",
             tag, op, va, vb, result, zero, illegal_op, lat);
    @(negedge clk);
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    a          = '0;
    b          = '0;
    alucontrol = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_illegal", 32'(illegal_op), 32'd0);
    reset = 1'b0;

    run_op("add",     4'b0010, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1);
    run_op("sub",     4'b0110, 32'd5, 32'd3, 32'd2, 1'b0, 1'b0, 1);
    run_op("sub_eq",  4'b0110, 32'd7, 32'd7, 32'd0, 1'b1, 1'b0, 1);
    run_op("xor",     4'b0000, 32'h0FFF_FFFF, 32'h0AAA_AAAA, 32'h0555_5555, 1'b0, 1'b0, 1);
    run_op("and",     4'b0011, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 1'b0, 1);
    run_op("or",      4'b1000, 32'h1200_0000, 32'h0000_0034, 32'h1200_0034, 1'b0, 1'b0, 1);
    run_op("add_wrap",4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1);
    run_op("sra",     4'b0100, 32'h8000_0000, 32'd1, 32'hC000_0000, 1'b0, 1'b0, 2);
    run_op("srl",     4'b0101, 32'h8000_0000, 32'd1, 32'h4000_0000, 1'b0, 1'b0, 2);
    run_op("sll31",   4'b0001, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 32);
    run_op("sll0",    4'b0001, 32'h0000_1234, 32'd0, 32'h0000_1234, 1'b0, 1'b0, 1);
    run_op("sra_hib", 4'b0100, 32'h8000_0000, 32'hFFFF_FF24, 32'hF800_0000, 1'b0, 1'b0, 5);
    run_op("bad_op",  4'b1111, 32'h1234_5678, 32'd9, 32'd0, 1'b1, 1'b1, 1);
`ifdef ALU_SLT_EN
    run_op("slt",     4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1);
`else
    run_op("slt",     4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b1, 1);
`endif

    // Backpressure: result held, new requests ignored while DONE waits.
    out_ready = 1'b0;
    @(negedge clk);
    in_valid   = 1'b1;
    alucontrol = 4'b0010;
    a          = 32'd10;
    b          = 32'd20;
    @(negedge clk);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_result", result, 32'd30);
    for (int i = 0; i < 5; i++) begin
      alucontrol = 4'b0110;
      a          = 32'd99;
      b          = 32'd1;
      @(negedge clk);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_result", result, 32'd30);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("bp_no_ghost", 32'(out_valid), 32'd0);
    $display("op backpressure add a=0000000a b=00000014 -> result held 30 for 5 cycles");

    // Reset in the middle of a long shift.
    in_valid   = 1'b1;
    alucontrol = 4'b0001;
    a          = 32'd1;
    b          = 32'd20;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_no_partial", 32'(out_valid), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_result", result, 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    $display("op sll_reset a=00000001 b=00000014 -> aborted by reset");
    run_op("add_after_rst", 4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
